dsp_iq_collector: RTL and testbench

- Collects decimated I/Q results from the four downconversion channels of the dsp datapath (ref, a, b, c; each strobed at the CIC output rate).
- Holds each result until it is consumed.
- Serialises the held results onto one valid/ready stream through a round-robin scheduler, so one downstream consumer (CSR FIFO or DMA packer) serves all channels.
- Detects and counts overruns when a channel produces a new result before its previous one has been forwarded.

---
 rtl/dsp_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/dsp_iq_collector.sv | 149 ++++++++++++++
 tb/tb_dsp_iq_collector.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared dsp datapath constants, channel indices and the packed-slice helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsp_pkg;

  // Channel count and sample width of the downconversion datapath
  localparam int N_CH  = 4;
  localparam int W     = 20;
  localparam int CNT_W = 16;
  localparam int CH_W  = $clog2(N_CH);

  // Fixed channel order
  localparam int CH_IDX_REF = 0;
  localparam int CH_IDX_A   = 1;
  localparam int CH_IDX_B   = 2;
  localparam int CH_IDX_C   = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } coll_state_e;

  // Channel k of a packed per-channel bus lives at bits [k*W +: W]
  function automatic logic [W-1:0] ch_slice(input logic [N_CH*W-1:0] bus,
                                            input int unsigned       k);
    return bus[k*W +: W];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority rotate: grants the lowest requester at or after ptr (cyclic).
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken.
// Ports: req (request vector), ptr (start index), gnt (one-hot), gnt_idx, gnt_any.
module rr_arbiter
  import dsp_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = CH_W'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_iq_collector.sv
// Collects per-channel decimated I/Q results and serialises them onto one valid/ready stream.
// Latency: strobe rise in cycle N -> out_valid in cycle N+2 when idle; 1 beat/cycle back-to-back.
// Backpressure: out_ready low holds the beat stable; new results overwrite held ones and count as overruns.
// Ports: clk/reset_n; ch_enable, strobe, res_i/res_q (packed per channel) in;
//        out_valid/out_ready/out_ch/out_i/out_q/out_frame stream; overrun_clr in, overrun_flags/overrun_cnt out.
module dsp_iq_collector
  import dsp_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   ch_enable,
  input  logic [N_CH-1:0]   strobe,
  input  logic [N_CH*W-1:0] res_i,
  input  logic [N_CH*W-1:0] res_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [W-1:0]      out_i,
  output logic [W-1:0]      out_q,
  output logic [7:0]        out_frame,
  input  logic              overrun_clr,
  output logic [N_CH-1:0]   overrun_flags,
  output logic [CNT_W-1:0]  overrun_cnt
);

  logic [N_CH-1:0]  strobe_d;
  logic             armed;
  logic [N_CH-1:0]  pending;
  logic [W-1:0]     hold_i [N_CH];
  logic [W-1:0]     hold_q [N_CH];
  logic [CH_W-1:0]  rr_ptr;
  coll_state_e      state;

  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  gnt;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic             out_free;
  logic             do_grant;
  logic [N_CH-1:0]  ovr_ev;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_next;
  logic [N_CH-1:0]  flags_next;

  // armed stays low for the first cycle after reset release so that a strobe
  // already high at release is absorbed into strobe_d instead of reading as an edge.
  assign rise     = strobe & ~strobe_d & ch_enable & {N_CH{armed}};
  assign req      = pending & ch_enable;
  assign out_free = (state == ST_IDLE) || (out_valid && out_ready);
  assign do_grant = out_free && gnt_any;

  // A rise on a channel being granted this same cycle just re-arms it.
  assign ovr_ev   = rise & pending & ~(gnt & {N_CH{do_grant}});

  rr_arbiter u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Clear drops the old totals but the events of this cycle still land.
  always_comb begin
    cnt_sum = overrun_clr ? '0 : {1'b0, overrun_cnt};
    for (int k = 0; k < N_CH; k++) begin
      cnt_sum = cnt_sum + (CNT_W+1)'(ovr_ev[k]);
    end
    cnt_next   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    flags_next = overrun_clr ? ovr_ev : (overrun_flags | ovr_ev);
  end

  // Edge detect, capture and pending bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_d <= '0;
      armed    <= 1'b0;
      pending  <= '0;
      for (int k = 0; k < N_CH; k++) begin
        hold_i[k] <= '0;
        hold_q[k] <= '0;
      end
    end else begin
      strobe_d <= strobe;
      armed    <= 1'b1;
      for (int k = 0; k < N_CH; k++) begin
        if (rise[k]) begin
          hold_i[k] <= ch_slice(res_i, k);
          hold_q[k] <= ch_slice(res_q, k);
        end
        if (!ch_enable[k])
          pending[k] <= 1'b0;
        else if (rise[k])
          pending[k] <= 1'b1;
        else if (do_grant && gnt[k])
          pending[k] <= 1'b0;
      end
    end
  end

  // Output FSM, scheduler pointer and overrun accounting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      out_valid     <= 1'b0;
      out_ch        <= '0;
      out_i         <= '0;
      out_q         <= '0;
      out_frame     <= '0;
      rr_ptr        <= '0;
      overrun_flags <= '0;
      overrun_cnt   <= '0;
    end else begin
      overrun_flags <= flags_next;
      overrun_cnt   <= cnt_next;

      case (state)
        ST_IDLE: begin
          if (do_grant) begin
            state     <= ST_PRESENT;
            out_valid <= 1'b1;
          end
        end
        ST_PRESENT: begin
          // Accepted with nothing to re-grant: the register empties.
          if (out_ready && !gnt_any) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase

      if (do_grant) begin
        out_ch <= gnt_idx;
        out_i  <= hold_i[gnt_idx];
        out_q  <= hold_q[gnt_idx];
        rr_ptr <= (gnt_idx == CH_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
        if (gnt_idx == CH_W'(CH_IDX_REF))
          out_frame <= out_frame + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dsp_iq_collector.sv
module tb_dsp_iq_collector;

  logic        clk;
  logic        reset_n;
  logic [3:0]  ch_enable;
  logic [3:0]  strobe;
  logic [79:0] res_i;
  logic [79:0] res_q;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  logic [19:0] out_i;
  logic [19:0] out_q;
  logic [7:0]  out_frame;
  logic        overrun_clr;
  logic [3:0]  overrun_flags;
  logic [15:0] overrun_cnt;

  typedef struct {
    logic [1:0]  ch;
    logic [19:0] i;
    logic [19:0] q;
    logic [7:0]  frame;
    int          cyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] exp_frame;

  dsp_iq_collector dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ch_enable     (ch_enable),
    .strobe        (strobe),
    .res_i         (res_i),
    .res_q         (res_q),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ch        (out_ch),
    .out_i         (out_i),
    .out_q         (out_q),
    .out_frame     (out_frame),
    .overrun_clr   (overrun_clr),
    .overrun_flags (overrun_flags),
    .overrun_cnt   (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_res(input int k, input logic [19:0] i, input logic [19:0] q);
    res_i[k*20 +: 20] = i;
    res_q[k*20 +: 20] = q;
  endtask

  // Expected beats are pushed in the order the scheduler must grant them.
  task automatic push(input int k, input logic [19:0] i, input logic [19:0] q, input int c);
    exp_t e;
    if (k == 0) exp_frame = exp_frame + 8'd1;
    e.ch    = 2'(k);
    e.i     = i;
    e.q     = q;
    e.frame = exp_frame;
    e.cyc   = c;
    sbq.push_back(e);
  endtask

  task automatic pulse(input logic [3:0] m);
    strobe = m;
    tick(1);
    strobe = 4'b0000;
    tick(1);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      tick(1);
      t++;
    end
    chk(tag, 64'(sbq.size()), 64'd0);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    strobe  = 4'b0000;
    tick(2);
    reset_n   = 1'b1;
    exp_frame = 8'd0;
    tick(2);
  endtask

  // Every accepted beat is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      n_cmp++;
      assert (sbq.size() > 0) else begin
        n_err++;
        $error("FAIL beat_unexpected: observed ch=%0d i=%h, expected no beat", out_ch, out_i);
      end
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        n_cmp++;
        assert ({out_ch, out_i, out_q, out_frame} === {mon_e.ch, mon_e.i, mon_e.q, mon_e.frame}) else begin
          n_err++;
          $error("FAIL beat_data: observed ch=%0d i=%h q=%h fr=%0d expected ch=%0d i=%h q=%h fr=%0d",
                 out_ch, out_i, out_q, out_frame, mon_e.ch, mon_e.i, mon_e.q, mon_e.frame);
        end
        if (mon_e.cyc >= 0) begin
          n_cmp++;
          assert (cyc == mon_e.cyc) else begin
            n_err++;
            $error("FAIL beat_cycle: observed %0d expected %0d", cyc, mon_e.cyc);
          end
        end
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    ch_enable   = 4'hF;
    strobe      = 4'b0000;
    res_i       = '0;
    res_q       = '0;
    out_ready   = 1'b1;
    overrun_clr = 1'b0;
    exp_frame   = 8'd0;

    // Reset state
    tick(3);
    chk("rst_ctl", 64'({out_valid, out_ch, out_frame, overrun_flags}), 64'd0);
    chk("rst_i", 64'(out_i), 64'd0);
    chk("rst_q", 64'(out_q), 64'd0);
    chk("rst_cnt", 64'(overrun_cnt), 64'd0);
    reset_n = 1'b1;
    tick(8);

    // Single result, exact two-cycle latency
    set_res(1, 20'h12345, 20'hFFFFB);
    strobe = 4'b0010;
    push(1, 20'h12345, 20'hFFFFB, cyc + 2);
    tick(1);
    strobe = 4'b0000;
    tick(6);
    chk("t1_flags", 64'(overrun_flags), 64'd0);
    chk("t1_cnt", 64'(overrun_cnt), 64'd0);
    chk("t1_valid_low", 64'(out_valid), 64'd0);
    wait_drain("t1_drain");

    // Simultaneous strobes from a fresh pointer: ch0..ch3 on consecutive cycles
    reset_dut();
    for (int k = 0; k < 4; k++) set_res(k, 20'(k + 1), 20'(k + 16));
    strobe = 4'hF;
    for (int k = 0; k < 4; k++) push(k, 20'(k + 1), 20'(k + 16), cyc + 2 + k);
    tick(1);
    strobe = 4'b0000;
    tick(6);
    wait_drain("t2_drain");

    // Pointer wrapped to 0: ch0 must win over ch3
    set_res(0, 20'h00100, 20'h00001);
    set_res(3, 20'h00300, 20'h00003);
    strobe = 4'b1001;
    push(0, 20'h00100, 20'h00001, cyc + 2);
    push(3, 20'h00300, 20'h00003, cyc + 3);
    tick(1);
    strobe = 4'b0000;
    tick(6);
    wait_drain("t2_wrap_drain");

    // Backpressure with ch2 presented, ch2 re-strobing underneath
    out_ready = 1'b0;
    set_res(2, 20'd3, 20'h00042);
    strobe = 4'b0100;
    push(2, 20'd3, 20'h00042, -1);
    tick(1);
    strobe = 4'b0000;
    tick(1);
    for (int t = 0; t < 20; t++) begin
      chk("t3_hold", 64'({out_valid, out_ch, out_i, out_q, out_frame}),
          64'({1'b1, 2'd2, 20'd3, 20'h00042, exp_frame}));
      case (t)
        3:  begin set_res(2, 20'd5, 20'h00042); strobe = 4'b0100; end
        6:  begin set_res(2, 20'd7, 20'h00042); strobe = 4'b0100; end
        9:  begin set_res(2, 20'd9, 20'h00042); strobe = 4'b0100; end
        default: strobe = 4'b0000;
      endcase
      tick(1);
    end
    strobe = 4'b0000;
    chk("t3_flags", 64'(overrun_flags), 64'h4);
    chk("t3_cnt", 64'(overrun_cnt), 64'd2);
    push(2, 20'd9, 20'h00042, -1);
    out_ready = 1'b1;
    wait_drain("t3_drain");

    // Rise on ch0 in its own grant cycle
    out_ready = 1'b0;
    set_res(1, 20'h00011, 20'h00001);
    push(1, 20'h00011, 20'h00001, -1);
    pulse(4'b0010);
    set_res(0, 20'h00020, 20'h00002);
    push(0, 20'h00020, 20'h00002, -1);
    pulse(4'b0001);
    set_res(0, 20'h00021, 20'h00003);
    strobe    = 4'b0001;
    out_ready = 1'b1;
    push(0, 20'h00021, 20'h00003, -1);
    tick(1);
    strobe = 4'b0000;
    tick(4);
    wait_drain("t4_drain");
    chk("t4_flags", 64'(overrun_flags), 64'h4);
    chk("t4_cnt", 64'(overrun_cnt), 64'd2);

    // Masked channel produces nothing, then clear
    ch_enable = 4'b1110;
    for (int t = 0; t < 4; t++) begin
      set_res(0, 20'(20'h00500 + t), 20'd0);
      pulse(4'b0001);
    end
    tick(4);
    chk("t5_mask_flags", 64'(overrun_flags), 64'h4);
    chk("t5_mask_cnt", 64'(overrun_cnt), 64'd2);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    chk("t5_clr_flags", 64'(overrun_flags), 64'd0);
    chk("t5_clr_cnt", 64'(overrun_cnt), 64'd0);

    // Forced overruns: first pulse arms, one channel is granted, then 3 + 4 per pulse
    ch_enable = 4'hF;
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) pulse(4'hF);
    chk("t5_multi_cnt", 64'(overrun_cnt), 64'd7);
    chk("t5_multi_flags", 64'(overrun_flags), 64'hF);
    for (int t = 0; t < 17597; t++) pulse(4'hF);
    chk("t5_sat_cnt", 64'(overrun_cnt), 64'hFFFF);
    overrun_clr = 1'b1;
    strobe      = 4'hF;
    tick(1);
    overrun_clr = 1'b0;
    strobe      = 4'b0000;
    chk("t5_clr_race_flags", 64'(overrun_flags), 64'hF);
    chk("t5_clr_race_cnt", 64'(overrun_cnt), 64'd4);

    // Async reset mid-beat with pending channels
    reset_dut();
    out_ready = 1'b0;
    set_res(2, 20'h00222, 20'd0);
    pulse(4'b0100);
    strobe = 4'b1011;
    tick(1);
    strobe = 4'b1000;
    tick(1);
    chk("t6_pre_valid", 64'({out_valid, out_ch}), 64'({1'b1, 2'd2}));
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    tick(2);
    #3;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    exp_frame = 8'd0;
    tick(10);
    chk("t6_no_beat", 64'(out_valid), 64'd0);
    strobe = 4'b0000;
    tick(1);
    set_res(3, 20'h00333, 20'h00007);
    strobe = 4'b1000;
    push(3, 20'h00333, 20'h00007, cyc + 2);
    tick(1);
    strobe = 4'b0000;
    tick(5);
    wait_drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
